// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port
// indices, default memory depth and the per-transaction context kept
// between the handshake and the response.
package dm_pkg;

  localparam int NUM_PORTS     = 2;
  localparam int PORT_CORE     = 0;
  localparam int PORT_DBG      = 1;
  localparam int DM_DEPTH_LOG2 = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dm_state_e;

  // Context of the access in flight, latched at the handshake.
  typedef struct packed {
    logic owner;  // index of the port that issued the request
    logic we;     // write (1) / read (0)
    logic err;    // misaligned or out of range
  } dm_txn_t;

  // A byte address is bad when it is not word aligned or lies beyond the
  // last word of a 2**depth_log2-word memory.
  function automatic logic addr_err(input logic [31:0] addr, input int depth_log2);
    return (addr[1:0] != 2'b00) || ((addr >> (depth_log2 + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of request/response and memory-side signals around dm_arbiter.
// slave  : the arbiter's view.
// master : the environment's view (both requesters plus the memory).
interface dm_arbiter_if;
  import dm_pkg::*;

  logic [NUM_PORTS-1:0] req_valid;
  logic [NUM_PORTS-1:0] req_ready;
  logic [NUM_PORTS-1:0] req_we;
  logic [31:0]          req_addr0;
  logic [31:0]          req_addr1;
  logic [31:0]          req_wdata0;
  logic [31:0]          req_wdata1;
  logic [NUM_PORTS-1:0] rsp_valid;
  logic                 rsp_err;
  logic [31:0]          rsp_rdata;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_din;
  logic                 mem_we;
  logic [31:0]          mem_dout;

  modport slave (
    input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_dout,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_din, mem_we
  );

  modport master (
    output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_dout,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_din, mem_we
  );

endinterface

// File: rtl/dm_arb_pick.sv
// Two-way grant picker. A lone valid port always wins. On a tie:
//   DM_ARB_RR_EN defined   -> the port not granted last wins (round-robin)
//   DM_ARB_RR_EN undefined -> port 0 wins (fixed priority), last_grant ignored
module dm_arb_pick (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifndef DM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // One-hot grant among the valid ports.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
`ifdef DM_ARB_RR_EN
        grant = last_grant ? 2'b01 : 2'b10;
`else
        grant = 2'b01;
`endif
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// One access at a time: handshake -> ACCESS (memory driven) -> RESP (pulse).
// A new handshake may be taken in RESP, giving one access every two cycles.
// Optional: define DM_ARB_RR_EN for round-robin tie breaking; otherwise
// port 0 has fixed priority and no last-grant state exists.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int DEPTH_LOG2 = DM_DEPTH_LOG2
) (
  input logic         clk,
  input logic         rst_n,
  dm_arbiter_if.slave bus
);

  dm_state_e                       state_q, state_d;
  dm_txn_t                         txn_q, txn_d;
  logic [31:0]                     mem_addr_q, mem_addr_d;
  logic [31:0]                     mem_din_q, mem_din_d;
  logic                            mem_we_q, mem_we_d;
  logic [NUM_PORTS-1:0]            rsp_valid_q, rsp_valid_d;
  logic                            rsp_err_q, rsp_err_d;
  logic [31:0]                     rsp_rdata_q, rsp_rdata_d;

  logic [NUM_PORTS-1:0][31:0]      p_addr, p_wdata;
  logic [NUM_PORTS-1:0]            grant, ready, hs;
  logic                            accept, hs_port, last_grant;
  logic [31:0]                     sel_addr, sel_wdata;
  logic                            sel_we, sel_err;

  assign p_addr  = {bus.req_addr1, bus.req_addr0};
  assign p_wdata = {bus.req_wdata1, bus.req_wdata0};

  dm_arb_pick u_pick (
    .valid      (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Offer the grant only when no access is being driven; never in reset.
  assign accept    = rst_n && (state_q != ACCESS);
  assign ready     = accept ? grant : '0;
  assign hs        = bus.req_valid & ready;
  assign hs_port   = hs[PORT_DBG];
  assign sel_addr  = p_addr[hs_port];
  assign sel_wdata = p_wdata[hs_port];
  assign sel_we    = bus.req_we[hs_port];
  assign sel_err   = addr_err(sel_addr, DEPTH_LOG2);

`ifdef DM_ARB_RR_EN
  logic last_q, last_d;
  assign last_grant = last_q;

  // Remember which port took the most recent handshake.
  always_comb begin
    last_d = last_q;
    if (|hs) last_d = hs_port;
  end

  // Reset to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  assign last_grant = 1'b1;
`endif

  // Sequencer next state: latch a request, drive memory, then pulse response.
  always_comb begin
    state_d     = state_q;
    txn_d       = txn_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_we_d    = mem_we_q;
    rsp_valid_d = '0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ACCESS: begin
        // Memory read data is combinational on the address driven this cycle.
        rsp_valid_d[txn_q.owner] = 1'b1;
        rsp_err_d   = txn_q.err;
        rsp_rdata_d = (txn_q.we || txn_q.err) ? '0 : bus.mem_dout;
        mem_addr_d  = '0;
        mem_din_d   = '0;
        mem_we_d    = 1'b0;
        state_d     = RESP;
      end
      default: begin
        // IDLE and RESP behave alike: accept if granted, else go idle.
        state_d = IDLE;
        if (|hs) begin
          state_d                       = ACCESS;
          txn_d.owner                   = hs_port;
          txn_d.we                      = sel_we;
          txn_d.err                     = sel_err;
          mem_addr_d                    = '0;
          mem_addr_d[DEPTH_LOG2-1:0]    = sel_addr[DEPTH_LOG2+1:2];
          mem_din_d                     = sel_wdata;
          mem_we_d                      = sel_we & ~sel_err;
        end
      end
    endcase
  end

  // State and registered outputs; reset also kills a pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      txn_q       <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      txn_q       <= txn_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized traffic, checked
// cycle by cycle against a transaction-level model of the arbiter and memory.
module tb_dm_arbiter;

  localparam int DL2   = 7;
  localparam int WORDS = 1 << DL2;
`ifdef DM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; int dly; int hold; } req_t;
  typedef struct { int port; bit we; logic [31:0] addr; logic [31:0] wdata; } acc_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic mem_clr = 1'b1;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  dm_arbiter_if bus();
  dm_arbiter #(.DEPTH_LOG2(DL2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [31:0] init_word(input int i);
    return 32'(2 * (i + 1));
  endfunction

  // Memory attached to the DUT: combinational read, write on clock edge.
  logic [31:0] tb_mem [WORDS];
  assign bus.mem_dout = tb_mem[bus.mem_addr[DL2-1:0]];
  always @(posedge clk)
    if (mem_clr) for (int i = 0; i < WORDS; i++) tb_mem[i] <= init_word(i);
    else if (bus.mem_we) tb_mem[bus.mem_addr[DL2-1:0]] <= bus.mem_din;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(4 * WORDS));
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % WORDS);
  endfunction

  logic [31:0] ref_mem [WORDS];
  bit          acc_v = 0, rsp_v = 0;
  acc_t        acc;
  int          rsp_port;
  bit          rsp_err;
  logic [31:0] rsp_data;
  int          last_g = 1;

  // DUT observations for the directed checks.
  logic [1:0]  mon_hs = '0;
  int          hs_port_q[$], hs_cyc_q[$], rsp_port_q[$];
  logic [31:0] rsp_data_q[$];
  bit          rsp_err_q[$];
  int          we_cnt = 0;
  logic [31:0] we_addr = '0;

  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    int win;
    if (!rst_n) begin
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_err",   32'(bus.rsp_err), 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_mem_we",    32'(bus.mem_we), 0);
      chk("rst_mem_addr",  bus.mem_addr, 0);
      chk("rst_mem_din",   bus.mem_din, 0);
      acc_v = 0; rsp_v = 0; last_g = 1; mon_hs = '0;
    end else begin
      exp_rdy = '0; win = 0;
      if (!acc_v && bus.req_valid != 2'b00) begin
        if (bus.req_valid == 2'b11) win = RR ? 1 - last_g : 0;
        else                        win = bus.req_valid[1] ? 1 : 0;
        exp_rdy[win] = 1'b1;
      end
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("mem_we",    32'(bus.mem_we), 32'(acc_v && acc.we && !bad_addr(acc.addr)));
      chk("mem_addr",  bus.mem_addr, acc_v ? 32'(widx(acc.addr)) : 32'd0);
      chk("mem_din",   bus.mem_din, acc_v ? acc.wdata : 32'd0);
      chk("rsp_valid", 32'(bus.rsp_valid), rsp_v ? (32'd1 << rsp_port) : 32'd0);
      if (rsp_v) begin
        chk("rsp_err",   32'(bus.rsp_err), 32'(rsp_err));
        chk("rsp_rdata", bus.rsp_rdata, rsp_data);
      end
      mon_hs = bus.req_valid & bus.req_ready;
      for (int p = 0; p < 2; p++) begin
        if (mon_hs[p]) begin hs_port_q.push_back(p); hs_cyc_q.push_back(cyc); end
        if (bus.rsp_valid[p]) begin
          rsp_port_q.push_back(p); rsp_data_q.push_back(bus.rsp_rdata); rsp_err_q.push_back(bus.rsp_err);
        end
      end
      if (bus.mem_we) begin we_cnt++; we_addr = bus.mem_addr; end
      // advance: access this cycle becomes next cycle's response
      rsp_v = acc_v;
      if (acc_v) begin
        rsp_port = acc.port;
        rsp_err  = bad_addr(acc.addr);
        rsp_data = (acc.we || rsp_err) ? 32'd0 : ref_mem[widx(acc.addr)];
        if (acc.we && !rsp_err) ref_mem[widx(acc.addr)] = acc.wdata;
      end
      acc_v = (exp_rdy != 2'b00);
      if (acc_v) begin
        acc.port  = win;
        acc.we    = bus.req_we[win];
        acc.addr  = win ? bus.req_addr1 : bus.req_addr0;
        acc.wdata = win ? bus.req_wdata1 : bus.req_wdata0;
        last_g    = win;
      end
    end
  end

  // ---------------- requester drivers ----------------
  req_t rq0[$], rq1[$];
  req_t cur[2];
  bit   loaded[2], shown[2];
  int   dly[2], waited[2];

  function automatic req_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input int d, input int h);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.dly = d; r.hold = h;
    return r;
  endfunction

  function automatic req_t rnd_req();
    int k = int'($urandom_range(0, 99));
    logic [31:0] a;
    if (k < 5)       a = 32'(4 * (WORDS - 1));
    else if (k < 70) a = 32'($urandom_range(0, 15)) * 4;
    else if (k < 85) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
    else if (k < 95) a = 32'(4 * WORDS) + 32'($urandom_range(0, 1000));
    else             a = $urandom | 32'h8000_0000;
    return mk(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)),
              ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, 2)) : -1);
  endfunction

  task automatic step();
    @(posedge clk); #1; cyc++;
    for (int i = 0; i < 2; i++) begin
      if (shown[i]) begin
        if (mon_hs[i]) begin loaded[i] = 0; shown[i] = 0; end
        else if (cur[i].hold >= 0 && waited[i] >= cur[i].hold) begin loaded[i] = 0; shown[i] = 0; end
        else waited[i]++;
      end
      if (!loaded[i]) begin
        if (i == 0 && rq0.size() > 0) begin cur[0] = rq0.pop_front(); loaded[0] = 1; dly[0] = cur[0].dly; end
        if (i == 1 && rq1.size() > 0) begin cur[1] = rq1.pop_front(); loaded[1] = 1; dly[1] = cur[1].dly; end
      end
      if (loaded[i] && !shown[i]) begin
        if (dly[i] == 0) begin shown[i] = 1; waited[i] = 0; end
        else dly[i]--;
      end
    end
    bus.req_valid  = {shown[1], shown[0]};
    bus.req_we     = {cur[1].we, cur[0].we};
    bus.req_addr0  = cur[0].addr;
    bus.req_addr1  = cur[1].addr;
    bus.req_wdata0 = cur[0].wdata;
    bus.req_wdata1 = cur[1].wdata;
  endtask

  function automatic bit busy();
    return (rq0.size() != 0) || (rq1.size() != 0) || loaded[0] || loaded[1] || acc_v || rsp_v;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (busy() && n < budget) begin step(); n++; end
    chk(tag, 32'(busy()), 0);
  endtask

  task automatic clr_log();
    hs_port_q.delete(); hs_cyc_q.delete(); rsp_port_q.delete();
    rsp_data_q.delete(); rsp_err_q.delete(); we_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      cur[i] = mk(0, 0, 0, 0, -1); loaded[i] = 0; shown[i] = 0; dly[i] = 0; waited[i] = 0;
    end
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    bus.req_valid = '0; bus.req_we = '0;
    bus.req_addr0 = '0; bus.req_addr1 = '0; bus.req_wdata0 = '0; bus.req_wdata1 = '0;
    repeat (3) step();
    mem_clr = 1'b0; rst_n = 1'b1;

    // Tie from reset: both ports read words holding 2 and 4.
    clr_log();
    repeat (4) begin rq0.push_back(mk(0, 32'h0, 0, 0, -1)); rq1.push_back(mk(0, 32'h4, 0, 0, -1)); end
    drain("tie_drain", 100);
    chk("tie_hs_count", 32'(hs_port_q.size()), 8);
    for (int k = 0; k < 4 && k < hs_port_q.size() && k < rsp_data_q.size(); k++) begin
      chk("tie_grant", 32'(hs_port_q[k]), RR ? 32'(k % 2) : 32'd0);
      chk("tie_rdata", rsp_data_q[k], RR ? ((k % 2) ? 32'd4 : 32'd2) : 32'd2);
    end

    // Port 0 writes 0xDEADBEEF to 0x10 then reads it back.
    clr_log();
    rq0.push_back(mk(1, 32'h10, 32'hDEADBEEF, 0, -1));
    rq0.push_back(mk(0, 32'h10, 0, 0, -1));
    drain("wr_rd_drain", 50);
    chk("wr_we_count", 32'(we_cnt), 1);
    chk("wr_mem_addr", we_addr, 32'd4);
    chk("wr_rd_rsp_count", 32'(rsp_data_q.size()), 2);
    if (rsp_data_q.size() == 2) begin
      chk("rd_rdata", rsp_data_q[1], 32'hDEADBEEF);
      chk("rd_port", 32'(rsp_port_q[1]), 0);
      chk("rd_err", 32'(rsp_err_q[1]), 0);
    end

    // Port 1 errors (misaligned, out of range) and the last legal word.
    clr_log();
    rq1.push_back(mk(0, 32'h202, 0, 0, -1));
    rq1.push_back(mk(1, 32'h200, 32'h5555AAAA, 0, -1));
    rq1.push_back(mk(0, 32'h1FC, 0, 0, -1));
    drain("err_drain", 50);
    chk("err_we_count", 32'(we_cnt), 0);
    chk("err_rsp_count", 32'(rsp_data_q.size()), 3);
    for (int k = 0; k < 3 && k < rsp_data_q.size(); k++) begin
      chk("err_port", 32'(rsp_port_q[k]), 1);
      chk("err_flag", 32'(rsp_err_q[k]), (k < 2) ? 32'd1 : 32'd0);
      chk("err_rdata", rsp_data_q[k], (k < 2) ? 32'd0 : init_word(WORDS - 1));
    end

    // Back-to-back accesses from port 0.
    clr_log();
    rq0.push_back(mk(1, 32'h20, 32'hA1A1A1A1, 0, -1));
    rq0.push_back(mk(0, 32'h20, 0, 0, -1));
    rq0.push_back(mk(1, 32'h24, 32'hB2B2B2B2, 0, -1));
    rq0.push_back(mk(0, 32'h24, 0, 0, -1));
    drain("b2b_drain", 50);
    chk("b2b_hs_count", 32'(hs_cyc_q.size()), 4);
    for (int k = 1; k < 4 && k < hs_cyc_q.size(); k++)
      chk("b2b_spacing", 32'(hs_cyc_q[k] - hs_cyc_q[k-1]), 2);
    chk("b2b_rsp_count", 32'(rsp_data_q.size()), 4);
    if (rsp_data_q.size() == 4) begin
      chk("b2b_rd0", rsp_data_q[1], 32'hA1A1A1A1);
      chk("b2b_rd1", rsp_data_q[3], 32'hB2B2B2B2);
      for (int k = 0; k < 4; k++) chk("b2b_port", 32'(rsp_port_q[k]), 0);
    end

    // Port 1 valid only during ACCESS, then withdrawn.
    clr_log();
    rq0.push_back(mk(0, 32'h0, 0, 0, -1));
    rq1.push_back(mk(0, 32'h4, 0, 1, 0));
    drain("wd_drain", 50);
    chk("wd_hs_count", 32'(hs_port_q.size()), 1);
    chk("wd_rsp_count", 32'(rsp_port_q.size()), 1);
    if (rsp_port_q.size() == 1) chk("wd_rsp_port", 32'(rsp_port_q[0]), 0);

    // Reset during the ACCESS cycle of a write to 0x8.
    rq0.push_back(mk(1, 32'h8, 32'h12345678, 0, -1));
    n = 0;
    do begin step(); n++; end while (!mon_hs[0] && n < 20);
    chk("rst_wr_hs", 32'(mon_hs[0]), 1);
    rst_n = 1'b0;
    rq0.push_back(mk(0, 32'h8, 0, 0, -1));
    rq1.push_back(mk(0, 32'hC, 0, 0, -1));
    repeat (2) step();
    clr_log();
    rst_n = 1'b1;
    drain("rst_drain", 50);
    chk("rst_word2", tb_mem[2], init_word(2));
    chk("rst_rsp_count", 32'(rsp_port_q.size()), 2);
    if (hs_port_q.size() > 0) chk("rst_first_grant", 32'(hs_port_q[0]), 0);
    if (rsp_data_q.size() > 0) chk("rst_rd_word2", rsp_data_q[0], init_word(2));

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if (rq0.size() < 2 && $urandom_range(0, 2) == 0) rq0.push_back(rnd_req());
      if (rq1.size() < 2 && $urandom_range(0, 2) == 0) rq1.push_back(rnd_req());
      step();
    end
    drain("rnd_drain", 300);
    for (int i = 0; i < WORDS; i++) chk("mem_final", tb_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer that shares the single-port 128-word data memory between the core load/store unit (port 0) and a debug/DMA master (port 1). It accepts one request at a time over a valid/ready handshake, converts byte addresses to word indices, and drives the memory's address, data and write-enable. It returns read data or an error as a one-cycle response pulse to the port that issued the request. The block sits between both masters and the data memory instance.

## Interface
- DEPTH_LOG2, 7: log2 of memory depth in words; legal byte range is 0 .. 4*2^DEPTH_LOG2-1.
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-port request valid; bit i is port i.
- req_ready  out  2  per-port accept; at most one bit high at a time.
- req_we  in  2  per-port write (1) / read (0).
- req_addr0, req_addr1  in  32 each  byte addresses.
- req_wdata0, req_wdata1  in  32 each  write data.
- rsp_valid  out  2  one-cycle response pulse to the owning port.
- rsp_err  out  1  response error flag, qualified by rsp_valid.
- rsp_rdata  out  32  read data, qualified by rsp_valid.
- mem_addr  out  32  word index to memory: zero-extended req_addr[DEPTH_LOG2+1:2].
- mem_din  out  32  write data to memory.
- mem_we  out  1  memory write enable.
- mem_dout  in  32  combinational read data from memory.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state IDLE.
- Accept: req_ready[i] asserted combinationally only in IDLE or RESP, only for the arbitration winner among valid ports. Handshake = req_valid[i] & req_ready[i]; on handshake, latch owner, we, addr, wdata; go to ACCESS.
- ACCESS: mem_addr from latched address; mem_din = latched wdata; mem_we = latched we & ~err. At the clock edge, capture rsp_rdata = (we | err) ? 0 : mem_dout and rsp_err; go to RESP.
- RESP: rsp_valid[owner] = 1 for exactly one cycle. If a handshake occurs in the same cycle, go to ACCESS; otherwise go to IDLE.
- Error: addr[1:0] != 0 or addr[31:DEPTH_LOG2+2] != 0. The memory is not written, rsp_err = 1, rsp_rdata = 0.
- Arbitration with both ports valid: see Configuration. With a single port valid, that port always wins.
- Outside ACCESS: mem_we = 0, mem_addr = 0, mem_din = 0.
- Requesters must hold valid and all payload fields stable until the handshake; a request withdrawn before the handshake is dropped without side effect.
- Reset mid-transaction aborts it: no response is issued, and any write still pending in ACCESS is not committed because mem_we is forced to 0 while rst_n is low.

## Timing
- Handshake in cycle N, mem_we asserted during N+1 (write commits at the end of N+1), rsp_valid in N+2.
- Peak throughput is one access every 2 cycles, achieved by back-to-back handshakes in RESP.
- Reset values: req_ready = 0 while in reset, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, mem_we = 0, mem_addr = 0, mem_din = 0, last-grant = 1 (port 0 wins the first tie).
- A read in cycle N+1 observes every write committed at or before the end of cycle N.

## Configuration
- DM_ARB_RR_EN defined: round-robin. On a tie, the port not granted last wins. The last-grant register updates on every handshake.
- DM_ARB_RR_EN undefined: fixed priority, port 0 always wins a tie. The last-grant register is not built.

## Structure
- Shared package (dm_pkg): state encoding enum (IDLE, ACCESS, RESP), port index constants (PORT_CORE = 0, PORT_DBG = 1), and the DEPTH_LOG2 default.
- Sub-module dm_arb_pick: combinational two-way picker (valid[1:0], last_grant) -> grant[1:0]. It holds the DM_ARB_RR_EN switch.

## Test plan
- Port 0 writes 0xDEADBEEF to 0x10, then reads 0x10 -> mem_we high at N+1 with mem_addr = 4; read response rsp_rdata = 0xDEADBEEF, rsp_err = 0, on rsp_valid[0] only.
- Both ports valid every cycle from reset, reading 0x0 and 0x4 with memory preloaded to 2 and 4 -> RR: grants alternate 0,1,0,1 and responses alternate 2,4; fixed: port 0 always granted, port 1 starved.
- Port 1 reads 0x202 (misaligned) and 0x200 (out of range) -> rsp_err = 1, rsp_rdata = 0, no mem_we pulse.
- Port 0 handshake in RESP of the previous access -> accesses spaced exactly 2 cycles apart, responses in order, owners correct.
- rst_n pulsed low during ACCESS of a write to 0x8 -> no rsp_valid, memory word 2 unchanged, all outputs at reset values, first post-reset tie granted to port 0.
- Port 1 raises valid and drops it before winning arbitration -> no handshake, no response, no memory access.
